// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the write-back stage: widths and the
// bit layout of the MEM/WB write-back control bundle.
package wb_regfile_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int REG_N       = 1 << ADDR_W;

  localparam int WB_W        = 7;
  localparam int WB_REGWRITE = 6;
  localparam int WB_MEMTOREG = 5;
  localparam int WB_RD_MSB   = 4;
  localparam int WB_RD_LSB   = 0;

endpackage

// File: rtl/wb_regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by ID issue and
// cleared by write-back commit. Optional same-cycle clear masking via REGFILE_BYPASS_EN.
module wb_scoreboard
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy
);

  logic [REG_N-1:0] busy;
  logic [REG_N-1:0] busy_nxt;

  // Set is applied after clear so a newer producer stays outstanding.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en && set_idx != '0) busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_comb begin
    rs_busy = busy[rs_addr];
    rt_busy = busy[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (clr_en && clr_idx == rs_addr) rs_busy = 1'b0;
    if (clr_en && clr_idx == rt_addr) rt_busy = 1'b0;
`endif
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the result word, commits it to the 32-entry
// register file and serves the two ID read ports. Define REGFILE_BYPASS_EN for same-cycle forwarding.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WB_W-1:0]   MEM_WB_wb,
  input  logic [DATA_W-1:0] MEM_WB_alu,
  input  logic [DATA_W-1:0] MEM_WB_mem,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data,
  input  logic              id_issue,
  input  logic [ADDR_W-1:0] id_issue_rd,
  output logic              id_rs_busy,
  output logic              id_rt_busy,
  output logic              wb_commit,
  output logic [ADDR_W-1:0] wb_commit_rd
);

  logic [DATA_W-1:0] regs [REG_N];
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;

  assign wb_rd   = MEM_WB_wb[WB_RD_MSB:WB_RD_LSB];
  assign wb_data = MEM_WB_wb[WB_MEMTOREG] ? MEM_WB_mem : MEM_WB_alu;
  assign wb_we   = MEM_WB_wb[WB_REGWRITE] && (wb_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
      wb_commit    <= 1'b0;
      wb_commit_rd <= '0;
    end else begin
      if (wb_we) begin
        regs[wb_rd]  <= wb_data;
        wb_commit_rd <= wb_rd;
      end
      wb_commit <= wb_we;
    end
  end

  // Entry 0 is never written, but the read is still forced for robustness.
  always_comb begin
    id_rs_data = regs[id_rs_addr];
    id_rt_data = regs[id_rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_we && id_rs_addr == wb_rd) id_rs_data = wb_data;
    if (wb_we && id_rt_addr == wb_rd) id_rt_data = wb_data;
`endif
    if (id_rs_addr == '0) id_rs_data = '0;
    if (id_rt_addr == '0) id_rt_data = '0;
  end

  wb_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (id_issue),
    .set_idx (id_issue_rd),
    .clr_en  (wb_we),
    .clr_idx (wb_rd),
    .rs_addr (id_rs_addr),
    .rt_addr (id_rt_addr),
    .rs_busy (id_rs_busy),
    .rt_busy (id_rt_busy)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps followed by random
// traffic, compared against an array-based register/scoreboard model.
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [6:0]  MEM_WB_wb;
  logic [31:0] MEM_WB_alu;
  logic [31:0] MEM_WB_mem;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        id_issue;
  logic [4:0]  id_issue_rd;
  logic        id_rs_busy;
  logic        id_rt_busy;
  logic        wb_commit;
  logic [4:0]  wb_commit_rd;

  wb_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_WB_wb    (MEM_WB_wb),
    .MEM_WB_alu   (MEM_WB_alu),
    .MEM_WB_mem   (MEM_WB_mem),
    .id_rs_addr   (id_rs_addr),
    .id_rt_addr   (id_rt_addr),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .id_issue     (id_issue),
    .id_issue_rd  (id_issue_rd),
    .id_rs_busy   (id_rs_busy),
    .id_rt_busy   (id_rt_busy),
    .wb_commit    (wb_commit),
    .wb_commit_rd (wb_commit_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state as plain arrays.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_commit;
  logic [4:0]  m_commit_rd;

  // Values observed in the most recent cycle, for directed literal checks.
  logic [31:0] last_rs_data, last_rt_data;
  logic        last_rs_busy, last_rt_busy;
  logic        last_commit;
  logic [4:0]  last_commit_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit we,
                                           input logic [4:0] rd, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (BYP && we && a == rd) return wd;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit we, input logic [4:0] rd);
    if (BYP && we && a == rd) return 32'h0;
    return {31'h0, m_busy[a]};
  endfunction

  task automatic cycle(input logic r, input logic [6:0] wb, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] rs, input logic [4:0] rt,
                       input logic iss, input logic [4:0] ird);
    bit          we;
    logic [4:0]  rd;
    logic [31:0] wd;
    rst = r; MEM_WB_wb = wb; MEM_WB_alu = alu; MEM_WB_mem = mem;
    id_rs_addr = rs; id_rt_addr = rt; id_issue = iss; id_issue_rd = ird;
    rd = wb[4:0];
    we = wb[6] && (rd != 0);
    wd = wb[5] ? mem : alu;
    #1;
    last_rs_data = id_rs_data; last_rt_data = id_rt_data;
    last_rs_busy = id_rs_busy; last_rt_busy = id_rt_busy;
    check("rs_data", id_rs_data, exp_data(rs, we, rd, wd));
    check("rt_data", id_rt_data, exp_data(rt, we, rd, wd));
    check("rs_busy", {31'h0, id_rs_busy}, exp_busy(rs, we, rd));
    check("rt_busy", {31'h0, id_rt_busy}, exp_busy(rt, we, rd));
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 32'h0; m_busy[i] = 1'b0; end
      m_commit = 1'b0; m_commit_rd = 5'd0;
    end else begin
      if (we) begin m_regs[rd] = wd; m_busy[rd] = 1'b0; m_commit_rd = rd; end
      if (iss && ird != 0) m_busy[ird] = 1'b1;
      m_commit = we;
    end
    #1;
    last_commit = wb_commit; last_commit_rd = wb_commit_rd;
    check("wb_commit", {31'h0, wb_commit}, {31'h0, m_commit});
    check("wb_commit_rd", {27'h0, wb_commit_rd}, {27'h0, m_commit_rd});
  endtask

  task automatic idle_read(input logic [4:0] rs, input logic [4:0] rt);
    cycle(1'b0, 7'h00, 32'h0, 32'h0, rs, rt, 1'b0, 5'd0);
  endtask

  initial begin
    logic [6:0]  rwb;
    logic [4:0]  rrs, rrt, rird;
    for (int i = 0; i < 32; i++) begin m_regs[i] = 32'h0; m_busy[i] = 1'b0; end
    m_commit = 1'b0; m_commit_rd = 5'd0;
    rst = 1'b1; MEM_WB_wb = 7'h0; MEM_WB_alu = 32'h0; MEM_WB_mem = 32'h0;
    id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_issue = 1'b0; id_issue_rd = 5'd0;
    @(posedge clk); #1;

    // Reset, then read rs=5 / rt=31.
    cycle(1'b1, 7'h00, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    idle_read(5'd5, 5'd31);
    check("rst_rs_data", last_rs_data, 32'h0);
    check("rst_rt_data", last_rt_data, 32'h0);
    check("rst_rs_busy", {31'h0, last_rs_busy}, 32'h0);
    check("rst_commit", {31'h0, last_commit}, 32'h0);

    // ALU write to r3, then load-data write to r4.
    cycle(1'b0, 7'b1000011, 32'hDEADBEEF, 32'h0BADF00D, 5'd3, 5'd1, 1'b0, 5'd0);
    check("w3_commit", {31'h0, last_commit}, 32'h1);
    check("w3_commit_rd", {27'h0, last_commit_rd}, 32'd3);
    idle_read(5'd3, 5'd4);
    check("r3_alu", last_rs_data, 32'hDEADBEEF);
    cycle(1'b0, 7'b1100100, 32'hCAFEBABE, 32'h12345678, 5'd0, 5'd0, 1'b0, 5'd0);
    idle_read(5'd4, 5'd3);
    check("r4_mem", last_rs_data, 32'h12345678);

    // RegWrite with rd=0: no write, no commit, commit_rd held.
    cycle(1'b0, 7'b1000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd0);
    check("r0_commit", {31'h0, last_commit}, 32'h0);
    check("r0_commit_rd", {27'h0, last_commit_rd}, 32'd4);
    idle_read(5'd0, 5'd0);
    check("r0_data", last_rs_data, 32'h0);

    // Same-cycle write/read of r7.
    cycle(1'b0, 7'b1000111, 32'h11111111, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    cycle(1'b0, 7'b1000111, 32'hA5A5A5A5, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0);
    check("r7_same_cycle", last_rs_data, BYP ? 32'hA5A5A5A5 : 32'h11111111);
    idle_read(5'd7, 5'd0);
    check("r7_after", last_rs_data, 32'hA5A5A5A5);

    // Scoreboard: issue r9, then commit r9.
    cycle(1'b0, 7'h00, 32'h0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9);
    check("b9_issue_edge", {31'h0, last_rs_busy}, 32'h0);
    idle_read(5'd9, 5'd9);
    check("b9_set", {31'h0, last_rs_busy}, 32'h1);
    cycle(1'b0, 7'b1001001, 32'h99999999, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    check("b9_clear_cycle", {31'h0, last_rs_busy}, BYP ? 32'h0 : 32'h1);
    idle_read(5'd9, 5'd9);
    check("b9_cleared", {31'h0, last_rt_busy}, 32'h0);

    // Issue and commit of r9 in the same cycle: set wins; reset then clears it.
    cycle(1'b0, 7'h00, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9);
    cycle(1'b0, 7'b1001001, 32'h77777777, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9);
    idle_read(5'd9, 5'd9);
    check("b9_set_wins", {31'h0, last_rs_busy}, 32'h1);
    check("r9_written", last_rs_data, 32'h77777777);
    cycle(1'b1, 7'b1001001, 32'h55555555, 32'h0, 5'd9, 5'd9, 1'b1, 5'd10);
    idle_read(5'd9, 5'd10);
    check("rst_b9", {31'h0, last_rs_busy}, 32'h0);
    check("rst_r9", last_rs_data, 32'h0);
    check("rst_b10", {31'h0, last_rt_busy}, 32'h0);

    // Random traffic; reads often aimed at the write or issue target.
    for (int n = 0; n < 400; n++) begin
      rwb  = 7'($urandom);
      rird = 5'($urandom_range(0, 31));
      rrs  = ($urandom_range(0, 3) == 0) ? rwb[4:0] : 5'($urandom_range(0, 31));
      rrt  = ($urandom_range(0, 3) == 0) ? rird     : 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 59) == 0), rwb, $urandom, $urandom, rrs, rrt,
            1'($urandom_range(0, 1)), rird);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back end of the MEM/WB pipeline bus. Consumes the registered 7-bit write-back control bundle and the two candidate result words, selects the write-back value, and commits it to the 32-entry architectural register file. Serves the two ID-stage read ports and keeps a pending-write scoreboard that ID uses for stall decisions. Sits between the MEM/WB register and the ID stage of the 5-stage pipeline.

## Interface
- DATA_W, 32, register/data width
- ADDR_W, 5, register index width; depth = 2**ADDR_W

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- MEM_WB_wb  in  7  [6] RegWrite, [5] MemtoReg, [4:0] rd
- MEM_WB_alu  in  DATA_W  ALU result carried from EX/MEM
- MEM_WB_mem  in  DATA_W  load data carried from MEM
- id_rs_addr  in  ADDR_W  read port A index
- id_rt_addr  in  ADDR_W  read port B index
- id_rs_data  out  DATA_W  read port A data, combinational
- id_rt_data  out  DATA_W  read port B data, combinational
- id_issue  in  1  ID issues an instruction that will write id_issue_rd
- id_issue_rd  in  ADDR_W  destination of issued instruction
- id_rs_busy  out  1  id_rs_addr has a pending write
- id_rt_busy  out  1  id_rt_addr has a pending write
- wb_commit  out  1  registered pulse: write committed last cycle
- wb_commit_rd  out  ADDR_W  registered index of last commit

## Operation
- wb_data = MemtoReg ? MEM_WB_mem : MEM_WB_alu.
- Write enable = RegWrite && rd != 0. Register 0 never written; always reads 0.
- Reads: asynchronous array read, index 0 forced to 0.
- Scoreboard: one busy bit per register, bit 0 hard 0.
  - Set: id_issue && id_issue_rd != 0 sets busy[id_issue_rd].
  - Clear: write enable clears busy[rd].
  - Same index set and clear same cycle: set wins (newer producer outstanding).
  - id_rs_busy/id_rt_busy = busy[addr] of current state, masked by same-cycle clear (see Configuration).
- wb_commit/wb_commit_rd: registered copy of write enable and rd; rd held when no commit.
- RegWrite=1 with rd=0: no write, no clear, wb_commit stays 0.

## Timing
- Write: array updated at rising edge where write enable is high; visible on read ports same cycle only via bypass.
- Scoreboard: busy bit changes visible the cycle after set/clear edge.
- wb_commit: 1-cycle latency from MEM_WB_wb sample.
- Reset (rst=1 at edge): all registers 0, all busy bits 0, wb_commit 0, wb_commit_rd 0. Reset overrides any concurrent write or issue; reset mid-operation discards pending writes.
- Outputs after reset: id_rs_data/id_rt_data 0, busy outputs 0.

## Configuration
- REGFILE_BYPASS_EN defined: if write enable and read index == rd (nonzero), read port returns wb_data in the same cycle, and corresponding busy output reads 0 that cycle.
- Not defined: read ports return stored value (old data) during the write cycle; busy stays 1 until the following cycle; ID stalls one extra cycle.

## Structure
- Shared pipeline package: DATA_W/ADDR_W constants, MEM_WB_wb bit positions (WB_REGWRITE=6, WB_MEMTOREG=5, WB_RD msb/lsb 4:0).
- One sub-module: wb_scoreboard (busy bits, set/clear priority, busy lookups); array, mux, bypass in top.

## Test plan
- Reset then read rs=5, rt=31 -> both data 0, busy 0, wb_commit 0.
- MEM_WB_wb=7'b1000011, alu=0xDEADBEEF -> next cycle reg3=0xDEADBEEF, wb_commit=1, wb_commit_rd=3; MemtoReg=1 with mem=0x12345678 writes 0x12345678.
- MEM_WB_wb=7'b1000000, alu=0xFFFFFFFF -> reg0 reads 0, wb_commit=0.
- Same-cycle write rd=7 value 0xA5A5A5A5, rs=7 -> with REGFILE_BYPASS_EN id_rs_data=0xA5A5A5A5; without, old value.
- id_issue rd=9 -> id_rs_busy(rs=9)=1 next cycle; write rd=9 -> busy 0 after edge.
- Issue rd=9 and write rd=9 same cycle -> busy[9] remains 1; rst asserted with busy[9]=1 -> busy 0, reg9 0.
